// File: rtl/score_tracker.sv
// Run-score engine: prescaled score counter, circular run history and sorted top-N table.
// Optional feature macro: SCORE_BONUS_EN (adds bonus/bonus_valid ports and bonus accumulation).
module score_tracker #(
    parameter int unsigned CLOCK_FREQUENCY = 25000000,
    parameter int unsigned TICKS_PER_SEC   = 10,
    parameter int unsigned SCORE_WIDTH     = 32,
    parameter int unsigned HISTORY_DEPTH   = 256,
    parameter int unsigned TOP_N           = 4
) (
    input  logic                               Clock,
    input  logic                               reset,
    input  logic                               run_start,
    input  logic                               run_end,
    input  logic                               pause,
    output logic [SCORE_WIDTH-1:0]             score,
    output logic [SCORE_WIDTH-1:0]             best,
    output logic                               running,
    output logic                               busy,
    output logic                               new_best,
    output logic [$clog2(HISTORY_DEPTH):0]     hist_count,
    input  logic [$clog2(HISTORY_DEPTH)-1:0]   hist_rd_idx,
    output logic [SCORE_WIDTH-1:0]             hist_rd_data,
    input  logic [$clog2(TOP_N):0]             top_rd_idx,
    output logic [SCORE_WIDTH-1:0]             top_rd_data
`ifdef SCORE_BONUS_EN
    ,
    input  logic [SCORE_WIDTH-1:0]             bonus,
    input  logic                               bonus_valid
`endif
);

    localparam int unsigned PERIOD_RAW = CLOCK_FREQUENCY / TICKS_PER_SEC;
    localparam int unsigned PERIOD     = (PERIOD_RAW < 1) ? 1 : PERIOD_RAW;
    localparam int unsigned PW         = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned HIW        = $clog2(HISTORY_DEPTH);
    localparam int unsigned HCW        = HIW + 1;
    localparam int unsigned TIW        = $clog2(TOP_N) + 1;
    localparam int unsigned CW         = (TOP_N > 1) ? $clog2(TOP_N) : 1;

    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_COMMIT
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [HIW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [HCW-1:0]         hist_count_q, hist_count_d;
    logic                   ins_active_q, ins_active_d;
    logic [CW-1:0]          ins_idx_q, ins_idx_d;
    logic                   stop_q, stop_d;
    logic [SCORE_WIDTH-1:0] top_q [TOP_N];
    logic [SCORE_WIDTH-1:0] top_d [TOP_N];
    logic [SCORE_WIDTH-1:0] hist_mem [HISTORY_DEPTH];
    logic [SCORE_WIDTH-1:0] hist_rd_q;
    logic [SCORE_WIDTH-1:0] top_rd_q;

    logic                   tick;
    logic [SCORE_WIDTH+1:0] sum;
    logic [SCORE_WIDTH-1:0] score_adv;
    logic [SCORE_WIDTH-1:0] top_at;
    logic [HIW-1:0]         rd_phys;
    logic                   hist_we;
    logic                   new_best_d;

    assign tick    = (presc_q == PW'(PERIOD - 1));
    assign top_at  = top_q[ins_idx_q];
    assign rd_phys = wr_ptr_q - HIW'(1) - hist_rd_idx;

    // Sum is two bits wider so bonus + tick can never wrap before saturation.
    always_comb begin
        sum = {2'b00, score_q} + {{(SCORE_WIDTH + 1){1'b0}}, tick};
`ifdef SCORE_BONUS_EN
        if (bonus_valid) begin
            sum = sum + {2'b00, bonus};
        end
`endif
        score_adv = (sum > {2'b00, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_WIDTH-1:0];
    end

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        score_d      = score_q;
        wr_ptr_d     = wr_ptr_q;
        hist_count_d = hist_count_q;
        ins_active_d = ins_active_q;
        ins_idx_d    = ins_idx_q;
        stop_d       = stop_q;
        top_d        = top_q;
        hist_we      = 1'b0;
        new_best_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_start) begin
                    state_d = S_RUN;
                    score_d = '0;
                    presc_d = '0;
                end
            end

            S_RUN: begin
                if (!pause) begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    score_d = score_adv;
                end
                if (run_end) begin
                    state_d      = S_COMMIT;
                    ins_active_d = 1'b0;
                end else if (run_start) begin
                    score_d = '0;
                    presc_d = '0;
                end
            end

            S_COMMIT: begin
                if (!ins_active_q) begin
                    hist_we      = 1'b1;
                    wr_ptr_d     = wr_ptr_q + HIW'(1);
                    if (hist_count_q != HCW'(HISTORY_DEPTH)) begin
                        hist_count_d = hist_count_q + HCW'(1);
                    end
                    ins_active_d = 1'b1;
                    ins_idx_d    = CW'(TOP_N - 1);
                    stop_d       = 1'b0;
                end else begin
                    // One slot per cycle from the bottom up; the first non-greater entry freezes the scan.
                    if (!stop_q && (score_q > top_at)) begin
                        for (int unsigned k = 1; k < TOP_N; k++) begin
                            if (CW'(k - 1) == ins_idx_q) begin
                                top_d[k] = top_q[k-1];
                            end
                        end
                        top_d[ins_idx_q] = score_q;
                        new_best_d       = (ins_idx_q == '0);
                    end else begin
                        stop_d = 1'b1;
                    end
                    if (ins_idx_q == '0) begin
                        state_d      = S_IDLE;
                        ins_active_d = 1'b0;
                    end else begin
                        ins_idx_d = ins_idx_q - CW'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            score_q      <= '0;
            wr_ptr_q     <= '0;
            hist_count_q <= '0;
            ins_active_q <= 1'b0;
            ins_idx_q    <= '0;
            stop_q       <= 1'b0;
            hist_rd_q    <= '0;
            top_rd_q     <= '0;
            for (int unsigned k = 0; k < TOP_N; k++) begin
                top_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            score_q      <= score_d;
            wr_ptr_q     <= wr_ptr_d;
            hist_count_q <= hist_count_d;
            ins_active_q <= ins_active_d;
            ins_idx_q    <= ins_idx_d;
            stop_q       <= stop_d;
            top_q        <= top_d;
            hist_rd_q    <= (HCW'(hist_rd_idx) < hist_count_q) ? hist_mem[rd_phys] : '0;
            top_rd_q     <= (top_rd_idx < TIW'(TOP_N)) ? top_q[top_rd_idx[CW-1:0]] : '0;
        end
    end

    // History RAM has no reset: entries beyond hist_count are never exposed.
    always_ff @(posedge Clock) begin
        if (hist_we) begin
            hist_mem[wr_ptr_q] <= score_q;
        end
    end

    assign score        = score_q;
    assign best         = top_q[0];
    assign running      = (state_q == S_RUN);
    assign busy         = (state_q == S_COMMIT);
    assign new_best     = new_best_d;
    assign hist_count   = hist_count_q;
    assign hist_rd_data = hist_rd_q;
    assign top_rd_data  = top_rd_q;

endmodule
